// File: rtl/resettable_dpbram.sv
// Dual-port byte-lane block RAM that fills itself with RESET_VALUE after every reset.
// Port 1 clears the lower half and port 2 the upper half in parallel; ready rises once both halves are done.
module resettable_dpbram #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    BYTE_WIDTH   = 8,
    parameter int                    ADDR_WIDTH   = 10,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = 32'h23333333,
    parameter string                 WRITE_MODE   = "read_first",
    parameter int                    READ_LATENCY = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                en,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    write_en_1,
    input  logic [ADDR_WIDTH-1:0]               addr_1,
    input  logic [DATA_WIDTH-1:0]               data_in_1,
    output logic [DATA_WIDTH-1:0]               data_out_1,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    write_en_2,
    input  logic [ADDR_WIDTH-1:0]               addr_2,
    input  logic [DATA_WIDTH-1:0]               data_in_2,
    output logic [DATA_WIDTH-1:0]               data_out_2,
    output logic                                ready,
    output logic                                collision
);

    localparam int LANES = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] HALF_A = ADDR_WIDTH'(DEPTH / 2);
    localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(DEPTH / 2 - 1);
    localparam bit MODE_RF = (WRITE_MODE == "read_first");
    localparam bit MODE_WF = (WRITE_MODE == "write_first");
    localparam bit MODE_NC = (WRITE_MODE == "no_change");

    generate
        if ((BYTE_WIDTH < 1) || (DATA_WIDTH < BYTE_WIDTH) || ((DATA_WIDTH % BYTE_WIDTH) != 0) ||
            (ADDR_WIDTH < 1) || ((READ_LATENCY != 1) && (READ_LATENCY != 2)) ||
            !(MODE_RF || MODE_WF || MODE_NC)) begin : g_bad_params
            $error("resettable_dpbram: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_CLEAR = 2'd1,
        S_READY = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    ready_q, ready_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic [LANES-1:0]        wr_en_1_s, wr_en_2_s;
    logic [ADDR_WIDTH-1:0]   wr_addr_1_s, wr_addr_2_s;
    logic [DATA_WIDTH-1:0]   wr_data_1_s, wr_data_2_s;

    logic [DATA_WIDTH-1:0]   rd_1_q, rd_1_d, rd_2_q, rd_2_d;
    logic [DATA_WIDTH-1:0]   out_1_q, out_1_d, out_2_q, out_2_d;
    logic                    coll_1_q, coll_1_d, coll_2_q, coll_2_d;

    // Replace the lanes selected by lane_en with the new word, keep the rest.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [LANES-1:0]      lane_en
    );
        logic [DATA_WIDTH-1:0] result;
        result = old_word;
        for (int l = 0; l < LANES; l++) begin
            result[l*BYTE_WIDTH +: BYTE_WIDTH] = lane_en[l] ? new_word[l*BYTE_WIDTH +: BYTE_WIDTH]
                                                            : old_word[l*BYTE_WIDTH +: BYTE_WIDTH];
        end
        return result;
    endfunction

    // Same-port read-during-write result; other ports' writes never show up here.
    function automatic logic [DATA_WIDTH-1:0] port_read(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [LANES-1:0]      lane_en,
        input logic [DATA_WIDTH-1:0] prev_word
    );
        logic [DATA_WIDTH-1:0] result;
        if (MODE_WF) begin
            result = merge_lanes(old_word, new_word, lane_en);
        end else if (MODE_NC && (|lane_en)) begin
            result = prev_word;
        end else begin
            result = old_word;
        end
        return result;
    endfunction

    // Next state of the clear sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        case (state_q)
            S_HOLD: begin
                state_d = S_CLEAR;
                cnt_d   = {ADDR_WIDTH{1'b0}};
            end
            S_CLEAR: begin
                if (cnt_q == LAST_A) begin
                    state_d = S_READY;
                    ready_d = 1'b1;
                    cnt_d   = {ADDR_WIDTH{1'b0}};
                end else begin
                    cnt_d   = cnt_q + ADDR_WIDTH'(1);
                end
            end
            S_READY: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_HOLD;
                cnt_d   = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // Clear sequencer state; reset wins over everything, even mid-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_HOLD;
            cnt_q   <= {ADDR_WIDTH{1'b0}};
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Write-port mux: the clear sequence owns both ports until ready.
    always_comb begin
        wr_en_1_s   = {LANES{1'b0}};
        wr_en_2_s   = {LANES{1'b0}};
        wr_addr_1_s = addr_1;
        wr_addr_2_s = addr_2;
        wr_data_1_s = data_in_1;
        wr_data_2_s = data_in_2;
        if (reset) begin
            wr_en_1_s = {LANES{1'b0}};
            wr_en_2_s = {LANES{1'b0}};
        end else if (state_q == S_CLEAR) begin
            wr_en_1_s   = {LANES{1'b1}};
            wr_en_2_s   = {LANES{1'b1}};
            wr_addr_1_s = cnt_q;
            wr_addr_2_s = cnt_q + HALF_A;
            wr_data_1_s = RESET_VALUE;
            wr_data_2_s = RESET_VALUE;
        end else if ((state_q == S_READY) && en) begin
            wr_en_1_s = write_en_1;
            wr_en_2_s = write_en_2;
        end else begin
            wr_en_1_s = {LANES{1'b0}};
            wr_en_2_s = {LANES{1'b0}};
        end
    end

    // Storage array; port 1 is applied last so it owns overlapping lanes on a shared address.
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (wr_en_2_s[l]) begin
                mem_q[wr_addr_2_s][l*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data_2_s[l*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (wr_en_1_s[l]) begin
                mem_q[wr_addr_1_s][l*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data_1_s[l*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // First read stage and collision detect.
    always_comb begin
        rd_1_d   = rd_1_q;
        rd_2_d   = rd_2_q;
        coll_1_d = 1'b0;
        if (state_q != S_READY) begin
            rd_1_d = RESET_VALUE;
            rd_2_d = RESET_VALUE;
        end else if (en) begin
            rd_1_d   = port_read(mem_q[addr_1], data_in_1, write_en_1, rd_1_q);
            rd_2_d   = port_read(mem_q[addr_2], data_in_2, write_en_2, rd_2_q);
            coll_1_d = (addr_1 == addr_2) && (|(write_en_1 & write_en_2));
        end else begin
            rd_1_d = rd_1_q;
            rd_2_d = rd_2_q;
        end
    end

    // Optional output register stage; collision tracks it so the pulse lines up with the data.
    always_comb begin
        out_1_d  = out_1_q;
        out_2_d  = out_2_q;
        coll_2_d = coll_1_q;
        if (state_q != S_READY) begin
            out_1_d  = RESET_VALUE;
            out_2_d  = RESET_VALUE;
            coll_2_d = 1'b0;
        end else if (en) begin
            out_1_d = rd_1_q;
            out_2_d = rd_2_q;
        end else begin
            out_1_d = out_1_q;
            out_2_d = out_2_q;
        end
    end

    // Read pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_1_q   <= RESET_VALUE;
            rd_2_q   <= RESET_VALUE;
            out_1_q  <= RESET_VALUE;
            out_2_q  <= RESET_VALUE;
            coll_1_q <= 1'b0;
            coll_2_q <= 1'b0;
        end else begin
            rd_1_q   <= rd_1_d;
            rd_2_q   <= rd_2_d;
            out_1_q  <= out_1_d;
            out_2_q  <= out_2_d;
            coll_1_q <= coll_1_d;
            coll_2_q <= coll_2_d;
        end
    end

    assign data_out_1 = (READ_LATENCY == 2) ? out_1_q  : rd_1_q;
    assign data_out_2 = (READ_LATENCY == 2) ? out_2_q  : rd_2_q;
    assign collision  = (READ_LATENCY == 2) ? coll_2_q : coll_1_q;
    assign ready      = ready_q;

endmodule

// File: tb/tb_resettable_dpbram.sv
// Bench for resettable_dpbram: a default instance checked every cycle against a word-level model,
// plus a write_first / latency-2 instance checked with directed literals.
module tb_resettable_dpbram;

    localparam logic [31:0] RV   = 32'h23333333;
    localparam int          HALF = 512;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        en    = 1'b0;
    logic [3:0]  we1 = 4'h0, we2 = 4'h0;
    logic [9:0]  a1 = 10'd0, a2 = 10'd0;
    logic [31:0] d1 = 32'h0, d2 = 32'h0;
    logic [31:0] q1, q2;
    logic        rdy, coll;

    logic [3:0]  bwe1 = 4'h0, bwe2 = 4'h0;
    logic [9:0]  ba1 = 10'd0, ba2 = 10'd0;
    logic [31:0] bd1 = 32'h0, bd2 = 32'h0;
    logic [31:0] bq1, bq2;
    logic        brdy, bcoll;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 1'b0;

    // Model state: cycles since reset release, memory image, expected outputs.
    int          m_cnt;
    logic [31:0] m_mem [1024];
    logic [31:0] m_q1, m_q2;
    logic        m_rdy, m_coll;

    always #5 clk = ~clk;

    resettable_dpbram dut_a (
        .clk(clk), .reset(reset), .en(en),
        .write_en_1(we1), .addr_1(a1), .data_in_1(d1), .data_out_1(q1),
        .write_en_2(we2), .addr_2(a2), .data_in_2(d2), .data_out_2(q2),
        .ready(rdy), .collision(coll)
    );

    resettable_dpbram #(.WRITE_MODE("write_first"), .READ_LATENCY(2)) dut_b (
        .clk(clk), .reset(reset), .en(en),
        .write_en_1(bwe1), .addr_1(ba1), .data_in_1(bd1), .data_out_1(bq1),
        .write_en_2(bwe2), .addr_2(ba2), .data_in_2(bd2), .data_out_2(bq2),
        .ready(brdy), .collision(bcoll)
    );

    function automatic logic [31:0] apply(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] m);
        logic [31:0] mask;
        mask = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: reset holds, the next HALF cycles are the clear, then ready.
    always @(posedge clk) begin
        if (reset) begin
            m_cnt  <= 0;
            m_rdy  <= 1'b0;
            m_coll <= 1'b0;
            m_q1   <= RV;
            m_q2   <= RV;
        end else begin
            if (m_cnt <= HALF) m_cnt <= m_cnt + 1;
            if (m_cnt == HALF) begin
                m_rdy <= 1'b1;
                for (int i = 0; i < 1024; i++) m_mem[i] <= RV;
            end
            if (m_cnt <= HALF) begin
                m_q1   <= RV;
                m_q2   <= RV;
                m_coll <= 1'b0;
            end else if (en) begin
                m_q1   <= m_mem[a1];
                m_q2   <= m_mem[a2];
                m_coll <= (a1 == a2) && ((we1 & we2) != 4'h0);
                if (a1 == a2) begin
                    m_mem[a1] <= apply(apply(m_mem[a1], d2, we2), d1, we1);
                end else begin
                    m_mem[a1] <= apply(m_mem[a1], d1, we1);
                    m_mem[a2] <= apply(m_mem[a2], d2, we2);
                end
            end else begin
                m_coll <= 1'b0;
            end
        end
    end

    // Every-cycle comparison of the default instance against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("q1", q1, m_q1);
            check("q2", q2, m_q2);
            check("ready", {31'b0, rdy}, {31'b0, m_rdy});
            check("collision", {31'b0, coll}, {31'b0, m_coll});
        end
    end

    task automatic drive(input logic e, input logic [3:0] w1, input logic [9:0] ad1, input logic [31:0] dd1,
                         input logic [3:0] w2, input logic [9:0] ad2, input logic [31:0] dd2);
        en = e; we1 = w1; a1 = ad1; d1 = dd1; we2 = w2; a2 = ad2; d2 = dd2;
        @(posedge clk);
        #1;
    endtask

    // Counts edges after the first edge that samples reset low; ready must be seen after exactly HALF of them.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        check({name, "_rel_rdy"}, {31'b0, rdy}, 32'd0);
        check({name, "_rel_q1"}, q1, RV);
        while (n < 600) begin
            @(posedge clk);
            #1;
            n++;
            if (rdy) break;
        end
        check(name, 32'(n), 32'd512);
        check({name, "_b_rdy"}, {31'b0, brdy}, 32'd1);
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk_on = 1'b1;
        check("rst_ready", {31'b0, rdy}, 32'd0);
        check("rst_coll", {31'b0, coll}, 32'd0);
        check("rst_q1", q1, RV);
        check("rst_q2", q2, RV);
        check("rst_bq1", bq1, RV);
        check("rst_brdy", {31'b0, brdy}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_ready("clear_len");

        // Boundary reads on A; B writes lanes 0-1 of addr 7 while port 2 reads it.
        bwe1 = 4'b0011; ba1 = 10'd7; bd1 = 32'h00005a5a; bwe2 = 4'h0; ba2 = 10'd7;
        drive(1'b1, 4'h0, 10'd0, 32'h0, 4'h0, 10'd511, 32'h0);
        check("rd_0", q1, RV);
        check("rd_511", q2, RV);
        check("b_lat2_early", bq1, RV);
        bwe1 = 4'h0;
        drive(1'b1, 4'h0, 10'd512, 32'h0, 4'h0, 10'd1023, 32'h0);
        check("rd_512", q1, RV);
        check("rd_1023", q2, RV);
        check("b_wf_new", bq1, 32'h23335a5a);
        check("b_cross_old", bq2, RV);
        drive(1'b1, 4'hF, 10'd0, 32'h12345678, 4'h0, 10'd0, 32'h0);
        check("b_readback", bq2, 32'h23335a5a);
        check("b_coll", {31'b0, bcoll}, 32'd0);

        drive(1'b1, 4'hF, 10'd1, 32'h87654321, 4'h0, 10'd0, 32'h0);
        drive(1'b1, 4'h0, 10'd0, 32'h0, 4'h0, 10'd0, 32'h0);
        check("p2_rd_addr0", q2, 32'h12345678);
        drive(1'b1, 4'h0, 10'd0, 32'h0, 4'h0, 10'd1, 32'h0);
        check("p2_rd_addr1", q2, 32'h87654321);

        drive(1'b1, 4'hF, 10'd0, 32'hdeadbeef, 4'h0, 10'd0, 32'h0);
        check("rf_same_port", q1, 32'h12345678);
        check("cross_port_old", q2, 32'h12345678);
        drive(1'b1, 4'h0, 10'd0, 32'h0, 4'h0, 10'd0, 32'h0);
        check("rf_after", q1, 32'hdeadbeef);

        drive(1'b1, 4'hF, 10'd4, 32'haaaaaaaa, 4'b0011, 10'd2, 32'hcccccccc);
        drive(1'b1, 4'h0, 10'd4, 32'h0, 4'h0, 10'd2, 32'h0);
        check("indep_addr4", q1, 32'haaaaaaaa);
        check("indep_addr2", q2, 32'h2333cccc);
        check("model_addr2", m_mem[2], 32'h2333cccc);

        // Preload addr 3 so the untouched lane 0 already holds 8'h22.
        drive(1'b1, 4'h0, 10'd0, 32'h0, 4'hF, 10'd3, 32'h22222222);
        drive(1'b1, 4'b1100, 10'd3, 32'h11111111, 4'b0110, 10'd3, 32'h22222222);
        check("coll_pulse", {31'b0, coll}, 32'd1);
        drive(1'b1, 4'h0, 10'd3, 32'h0, 4'h0, 10'd3, 32'h0);
        check("coll_merge", q1, 32'h11112222);
        check("coll_merge_p2", q2, 32'h11112222);
        check("coll_once", {31'b0, coll}, 32'd0);
        check("model_addr3", m_mem[3], 32'h11112222);

        drive(1'b0, 4'h0, 10'd9, 32'h0, 4'hF, 10'd3, 32'h12121212);
        check("en0_hold_q1", q1, 32'h11112222);
        check("en0_hold_q2", q2, 32'h11112222);
        drive(1'b1, 4'h0, 10'd3, 32'h0, 4'h0, 10'd0, 32'h0);
        check("en0_no_write", q1, 32'h11112222);

        drive(1'b1, 4'b1100, 10'd5, 32'haaaaaaaa, 4'b0011, 10'd5, 32'hbbbbbbbb);
        check("no_overlap_coll", {31'b0, coll}, 32'd0);
        drive(1'b1, 4'h0, 10'd5, 32'h0, 4'h0, 10'd0, 32'h0);
        check("no_overlap_merge", q1, 32'haaaabbbb);
        drive(1'b1, 4'hF, 10'd8, 32'h1, 4'hF, 10'd9, 32'h2);
        check("diff_addr_coll", {31'b0, coll}, 32'd0);
        drive(1'b1, 4'hF, 10'd1023, 32'h0f0f0f0f, 4'h0, 10'd0, 32'h0);
        drive(1'b1, 4'h0, 10'd0, 32'h0, 4'h0, 10'd1023, 32'h0);
        check("top_addr", q2, 32'h0f0f0f0f);

        // Abort a clear at counter 100 while user writes are being requested.
        reset = 1'b1;
        drive(1'b1, 4'hF, 10'd0, 32'hffffffff, 4'hF, 10'd3, 32'hffffffff);
        reset = 1'b0;
        @(posedge clk);
        #1;
        repeat (100) begin
            @(posedge clk);
            #1;
        end
        check("abort_rdy", {31'b0, rdy}, 32'd0);
        check("abort_q1", q1, RV);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_ready("clear_len_2");

        drive(1'b1, 4'h0, 10'd3, 32'h0, 4'h0, 10'd4, 32'h0);
        check("reclr_addr3", q1, RV);
        check("reclr_addr4", q2, RV);
        drive(1'b1, 4'h0, 10'd0, 32'h0, 4'h0, 10'd1023, 32'h0);
        check("reclr_addr0", q1, RV);
        check("reclr_addr1023", q2, RV);
        drive(1'b0, 4'h0, 10'd0, 32'h0, 4'h0, 10'd0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/resettable_dpbram.md
RESETTABLE_DPBRAM -- requirements
Module: resettable_dpbram

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- DATA_WIDTH, 32, word width in bits; multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, bits per write-enable lane.
- ADDR_WIDTH, 10, word address width; DEPTH = 2**ADDR_WIDTH; ADDR_WIDTH >= 1.
- RESET_VALUE, 32'h23333333, DATA_WIDTH-bit word written to every location by the clear sequence.
- WRITE_MODE, "read_first", same-port read-during-write behaviour: "read_first", "write_first" or "no_change".
- READ_LATENCY, 1, read latency in cycles: 1 or 2 (2 adds an output register).

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, input, 1, sole clock; all logic on rising edge.
- reset, input, 1, synchronous, active-high reset.
- en, input, 1, global enable for both user ports.
- write_en_1, input, DATA_WIDTH/BYTE_WIDTH, port 1 byte-lane write enables.
- addr_1, input, ADDR_WIDTH, port 1 word address.
- data_in_1, input, DATA_WIDTH, port 1 write data.
- data_out_1, output, DATA_WIDTH, port 1 read data.
- write_en_2, input, DATA_WIDTH/BYTE_WIDTH, port 2 byte-lane write enables.
- addr_2, input, ADDR_WIDTH, port 2 word address.
- data_in_2, input, DATA_WIDTH, port 2 write data.
- data_out_2, output, DATA_WIDTH, port 2 read data.
- ready, output, 1, high when the clear sequence is complete and user accesses are accepted.
- collision, output, 1, one-cycle pulse flagging a same-address write-write conflict.

Function
REQ-003 The FSM SHALL have three states: HOLD (reset high), CLEAR, READY.
REQ-004 Any cycle with reset=1 SHALL move the FSM to HOLD, from any state, including mid-CLEAR.
REQ-005 On the first cycle with reset=0 after HOLD, the FSM SHALL enter CLEAR with its clear counter at 0.
REQ-006 Each CLEAR cycle SHALL write RESET_VALUE to address counter via port 1 and to address counter+DEPTH/2 via port 2, then increment the counter.
REQ-007 CLEAR SHALL last exactly DEPTH/2 cycles (512 at defaults), then the FSM SHALL move to READY; ready SHALL rise on the first READY cycle.
REQ-008 A reset during CLEAR SHALL abort the sequence; the next CLEAR SHALL restart at counter 0 and run the full DEPTH/2 cycles.
REQ-009 In HOLD and CLEAR, en, write_en_*, addr_* and data_in_* SHALL be ignored, and data_out_1/2 SHALL be RESET_VALUE.
REQ-010 In READY with en=1, each port SHALL write the data_in byte lanes whose write_en bit is set.
REQ-011 Read data SHALL appear on data_out READ_LATENCY cycles after the address is presented.
REQ-012 In READY with en=0, neither port SHALL read or write, and data_out_1/2 SHALL hold their values.
REQ-013 Same-port read during write SHALL return:
- read_first: the old word.
- write_first: the merged new word (unwritten lanes keep old data).
- no_change: the data_out value unchanged.
REQ-014 A cross-port read of an address being written in the same cycle SHALL return the old word, regardless of WRITE_MODE.
REQ-015 When both ports write the same address in the same cycle:
- Port 1 data SHALL win on overlapping lanes.
- Non-overlapping lanes SHALL take each port's data.
- collision SHALL pulse high for one cycle, registered and aligned with the first data_out cycle of that access, only if the lane masks overlap.
REQ-016 A parameter combination violating REQ-001 SHALL fail elaboration.

Reset
REQ-017 While reset=1, and on the cycle after reset is released, the outputs SHALL be: ready=0, collision=0, data_out_1=data_out_2=RESET_VALUE.
REQ-018 Memory contents SHALL be undefined until the first CLEAR completes; after any completed CLEAR every word SHALL equal RESET_VALUE.

Verification
REQ-019 The bench SHALL cover the following directed scenarios, one per line: stimulus -> required response, at defaults unless stated.
- Release reset, count cycles -> ready rises exactly 512 cycles later; reads of addresses 0, 511, 512, 1023 return 32'h23333333.
- Port 1 writes 32'h12345678 to addr 0 and 32'h87654321 to addr 1, then port 2 reads addr 0, 1 -> data_out_2 = 32'h12345678, then 32'h87654321, each 1 cycle after its address.
- Same cycle: port 1 writes 32'haaaaaaaa to addr 4; port 2 writes 32'hcccccccc with write_en_2=4'b0011 to addr 2 -> addr 4 reads 32'haaaaaaaa; addr 2 reads 32'h2333cccc.
- Both ports write addr 3, port 1 32'h11111111 mask 4'b1100, port 2 32'h22222222 mask 4'b0110 -> addr 3 reads 32'h11112222; collision pulses once.
- en=0 with write_en_2=4'b1111, addr 3, data_in_2 32'h12121212 -> addr 3 unchanged; data_out holds.
- Reset asserted at CLEAR counter 100, released -> ready stays 0 for a fresh 512 cycles; repeat scenario 1 with WRITE_MODE write_first and READ_LATENCY 2 -> same-port write returns new data after 2 cycles.
